// File: rtl/dm_store_buffer.sv
// rtl/dm_store_buffer.sv - posted-store FIFO that retires into DM by read-merge-write; loads own the port first.
// Optional define SB_FWD_EN: full-word forwarding from the youngest matching entry.
module dm_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_wdata,
  input  logic [3:0]  st_be,
  input  logic [31:0] st_pc,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  output logic        ld_stall,
  output logic [31:0] ld_rdata,
  output logic [31:0] dm_addr,
  output logic        dm_we,
  output logic [31:0] dm_wd,
  output logic [31:0] dm_pc,
  input  logic [31:0] dm_rd
);

  localparam int AW = $clog2(DEPTH);

  logic [29:0]      e_addr [DEPTH];
  logic [31:0]      e_data [DEPTH];
  logic [3:0]       e_be   [DEPTH];
  logic [31:0]      e_pc   [DEPTH];
  logic [DEPTH-1:0] e_valid;

  logic [AW-1:0] head, tail;
  logic [AW:0]   count;

  logic empty, full, accept, drain, match, load_go;
  logic unused_addr_lsb;

  assign empty  = (count == '0);
  assign full   = (count == (AW+1)'(DEPTH));
  assign accept = st_valid && st_ready;
  assign unused_addr_lsb = &{1'b0, st_addr[1:0]};

`ifdef SB_FWD_EN
  logic [AW-1:0] y_idx;
  logic [AW-1:0] scan_idx;
  logic          fwd_hit;

  // Scan from head towards tail so the last hit is the youngest store to that word.
  always_comb begin
    match    = 1'b0;
    y_idx    = '0;
    scan_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head + AW'(i);
      if (e_valid[scan_idx] && e_addr[scan_idx] == ld_addr[31:2]) begin
        match = 1'b1;
        y_idx = scan_idx;
      end
    end
  end

  assign fwd_hit = match && (e_be[y_idx] == 4'b1111);
  assign load_go = ld_valid && (!match || fwd_hit);
`else
  always_comb begin
    match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (e_valid[i] && e_addr[i] == ld_addr[31:2]) match = 1'b1;
    end
  end

  assign load_go = ld_valid && !match;
`endif

  // Arbitration uses only registered state plus the load request, never st_valid.
  always_comb begin
    st_ready = !full;
    ld_stall = 1'b0;
    ld_rdata = '0;
    dm_addr  = '0;
    dm_we    = 1'b0;
    dm_wd    = '0;
    dm_pc    = '0;
    drain    = 1'b0;
    if (!reset) begin
      if (load_go) begin
        dm_addr = ld_addr;
`ifdef SB_FWD_EN
        ld_rdata = fwd_hit ? e_data[y_idx] : dm_rd;
`else
        ld_rdata = dm_rd;
`endif
      end else if (!empty) begin
        drain    = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = {e_addr[head], 2'b00};
        dm_pc    = e_pc[head];
        ld_stall = ld_valid && match;
        for (int k = 0; k < 4; k++) begin
          dm_wd[8*k +: 8] = e_be[head][k] ? e_data[head][8*k +: 8] : dm_rd[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      e_valid <= '0;
    end else begin
      if (accept) begin
        e_valid[tail] <= 1'b1;
        tail          <= tail + 1'b1;
      end
      if (drain) begin
        e_valid[head] <= 1'b0;
        head          <= head + 1'b1;
      end
      case ({accept, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload needs no reset; the valid bits and count gate every use of it.
  always_ff @(posedge clk) begin
    if (accept) begin
      e_addr[tail] <= st_addr[31:2];
      e_data[tail] <= st_wdata;
      e_be[tail]   <= st_be;
      e_pc[tail]   <= st_pc;
    end
  end

endmodule

// File: tb/tb_dm_store_buffer.sv
// tb/tb_dm_store_buffer.sv - randomized and directed bench for dm_store_buffer against a queue-based model.
module tb_dm_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, st_valid, ld_valid;
  logic        st_ready, ld_stall, dm_we;
  logic [31:0] st_addr, st_wdata, st_pc, ld_addr;
  logic [3:0]  st_be;
  logic [31:0] ld_rdata, dm_addr, dm_wd, dm_pc, dm_rd;

  logic [31:0] dm_mem  [64];
  logic [31:0] ref_mem [64];

  typedef struct {
    logic [29:0] wa;
    logic [31:0] d;
    logic [3:0]  be;
    logic [31:0] pc;
  } st_t;
  st_t q[$];

  int total  = 0;
  int passes = 0;

  always #5 clk = ~clk;

  assign dm_rd = dm_mem[dm_addr[7:2]];

  dm_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_wdata(st_wdata), .st_be(st_be), .st_pc(st_pc),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_stall(ld_stall), .ld_rdata(ld_rdata),
    .dm_addr(dm_addr), .dm_we(dm_we), .dm_wd(dm_wd), .dm_pc(dm_pc), .dm_rd(dm_rd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = be[k] ? d[8*k +: 8] : old[8*k +: 8];
    return r;
  endfunction

  // One clock: drive at negedge, check the expected port behaviour, then advance DM and the model.
  task automatic step(input logic rst, input logic sv, input logic [31:0] sa, input logic [31:0] sw,
                      input logic [3:0] sbe, input logic [31:0] spc, input logic lv, input logic [31:0] la);
    logic        match, fwd, ld_ok, e_ready, e_drain, w_en;
    logic [31:0] fdata, e_wd, w_a, w_d;
    @(negedge clk);
    reset = rst; st_valid = sv; st_addr = sa; st_wdata = sw; st_be = sbe; st_pc = spc;
    ld_valid = lv; ld_addr = la;
    #1;
    match = 1'b0; fwd = 1'b0; fdata = '0; e_wd = '0;
    foreach (q[i]) begin
      if (q[i].wa == la[31:2]) begin
        match = 1'b1;
        fwd   = (q[i].be == 4'hf);
        fdata = q[i].d;
      end
    end
`ifdef SB_FWD_EN
    ld_ok = lv && (!match || fwd);
`else
    fwd   = 1'b0;
    ld_ok = lv && !match;
`endif
    e_ready = (q.size() < DEPTH);
    e_drain = !rst && !ld_ok && (q.size() > 0);
    chk("st_ready", {31'b0, st_ready}, {31'b0, e_ready});
    if (rst) begin
      chk("rst_dm_we", {31'b0, dm_we}, 32'd0);
      chk("rst_ld_stall", {31'b0, ld_stall}, 32'd0);
      chk("rst_ld_rdata", ld_rdata, 32'd0);
      chk("rst_dm_addr", dm_addr, 32'd0);
    end else if (ld_ok) begin
      chk("load_dm_we", {31'b0, dm_we}, 32'd0);
      chk("load_dm_addr", dm_addr, la);
      chk("load_stall", {31'b0, ld_stall}, 32'd0);
      chk("load_rdata", ld_rdata, (match && fwd) ? fdata : ref_mem[la[7:2]]);
    end else if (e_drain) begin
      e_wd = merge(ref_mem[q[0].wa[5:0]], q[0].d, q[0].be);
      chk("drain_dm_we", {31'b0, dm_we}, 32'd1);
      chk("drain_dm_addr", dm_addr, {q[0].wa, 2'b00});
      chk("drain_dm_wd", dm_wd, e_wd);
      chk("drain_dm_pc", dm_pc, q[0].pc);
      chk("drain_stall", {31'b0, ld_stall}, {31'b0, lv});
      chk("drain_rdata", ld_rdata, 32'd0);
    end else begin
      chk("idle_dm_we", {31'b0, dm_we}, 32'd0);
      chk("idle_dm_addr", dm_addr, 32'd0);
      chk("idle_dm_wd", dm_wd, 32'd0);
      chk("idle_dm_pc", dm_pc, 32'd0);
      chk("idle_stall", {31'b0, ld_stall}, 32'd0);
      chk("idle_rdata", ld_rdata, 32'd0);
    end
    w_en = dm_we; w_a = dm_addr; w_d = dm_wd;
    @(posedge clk);
    if (w_en) dm_mem[w_a[7:2]] = w_d;
    if (rst) begin
      q.delete();
    end else begin
      if (e_drain) begin
        ref_mem[q[0].wa[5:0]] = e_wd;
        void'(q.pop_front());
      end
      if (sv && e_ready) q.push_back('{wa: sa[31:2], d: sw, be: sbe, pc: spc});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 4'h0, 0, 1'b0, 0);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be, input logic [31:0] pc,
                       input logic lv, input logic [31:0] la);
    step(1'b0, 1'b1, a, d, be, pc, lv, la);
  endtask

  initial begin
    logic [31:0] v;
    reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_wdata = '0; st_be = '0; st_pc = '0;
    ld_valid = 1'b0; ld_addr = '0;
    for (int i = 0; i < 64; i++) begin
      v = $urandom;
      dm_mem[i] = v;
      ref_mem[i] = v;
    end
    dm_mem[8] = 32'hAABBCCDD;
    ref_mem[8] = 32'hAABBCCDD;

    step(1'b1, 1'b0, 0, 0, 4'h0, 0, 1'b0, 0);
    step(1'b1, 1'b0, 0, 0, 4'h0, 0, 1'b0, 0);
    idle(1);

    store(32'h10, 32'h12345678, 4'hf, 32'h3000, 1'b0, 0);
    idle(2);
    chk("single_store_mem", dm_mem[4], 32'h12345678);

    store(32'h20, 32'h00001100, 4'b0010, 32'h3004, 1'b0, 0);
    idle(2);
    chk("byte_merge_mem", dm_mem[8], 32'hAABB11DD);

    for (int i = 0; i <= DEPTH; i++)
      store(32'h80 + 32'(4*i), $urandom, 4'hf, 32'h3100 + 32'(4*i), 1'b1, 32'hC0);
    idle(DEPTH + 2);

    store(32'h40, 32'hCAFEF00D, 4'hf, 32'h3200, 1'b0, 0);
    step(1'b0, 1'b0, 0, 0, 4'h0, 0, 1'b1, 32'h40);
    step(1'b0, 1'b0, 0, 0, 4'h0, 0, 1'b1, 32'h40);
    idle(1);

    store(32'h60, 32'h01010101, 4'hf, 32'h3300, 1'b1, 32'hC4);
    store(32'h64, 32'h02020202, 4'hf, 32'h3304, 1'b1, 32'hC4);
    store(32'h68, 32'h03030303, 4'hf, 32'h3308, 1'b1, 32'hC4);
    step(1'b1, 1'b0, 0, 0, 4'h0, 0, 1'b0, 0);
    idle(4);

    store(32'h50, 32'h00000011, 4'b0001, 32'h3400, 1'b0, 0);
    store(32'h50, 32'h00000022, 4'b0001, 32'h3404, 1'b0, 0);
    idle(3);
    chk("same_word_byte0", {24'b0, dm_mem[20][7:0]}, 32'h22);

    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 99) == 0),
           1'($urandom_range(0, 1)),
           {26'b0, 4'($urandom_range(0, 15)), 2'($urandom)},
           $urandom, 4'($urandom), $urandom,
           ($urandom_range(0, 2) == 0),
           {26'b0, 4'($urandom_range(0, 15)), 2'($urandom)});
    end
    idle(DEPTH + 4);

    for (int i = 0; i < 64; i++) chk($sformatf("final_mem_%0d", i), dm_mem[i], ref_mem[i]);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
